// File: rtl/ins_fetch_pkg.sv
// ins_fetch_pkg: shared head package for the instruction fetch slice.
// Holds the next-PC select encodings, the opcode constants recognised by
// the decoder, and the fetch FSM state type.
package ins_fetch_pkg;

  typedef enum logic [1:0] {
    SEL_NEXT = 2'b00,  // NextIns
    SEL_REL  = 2'b01,  // RelJmp
    SEL_ABS  = 2'b10,  // AbsJmp
    SEL_HALT = 2'b11   // HALT
  } sel_e;

  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_HALT = 6'b111111;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_DECODE = 2'd2,
    S_HALTED = 2'd3
  } state_e;

endpackage

// File: rtl/ins_fetch_if.sv
// ins_fetch_if: instruction memory read bus.
//   imem_req   - read request (fetch unit -> memory)
//   imem_addr  - read address (fetch unit -> memory)
//   imem_ack   - response strobe, rdata valid in the same cycle (memory -> fetch unit)
//   imem_rdata - instruction word (memory -> fetch unit)
interface ins_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/ins_decode.sv
// ins_decode: combinational opcode to next-PC select decoder.
//   opcode - ins[31:26]
//   zero   - ALU zero flag, resolves beq/bne
//   sel    - next-PC select (NextIns/RelJmp/AbsJmp/HALT)
module ins_decode
  import ins_fetch_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic       zero,
  output sel_e       sel
);

  always_comb begin
    sel = SEL_NEXT;
    case (opcode)
      OP_J:    sel = SEL_ABS;
      OP_BEQ:  sel = zero ? SEL_REL : SEL_NEXT;
      OP_BNE:  sel = zero ? SEL_NEXT : SEL_REL;
      OP_HALT: sel = SEL_HALT;
      default: sel = SEL_NEXT;
    endcase
  end

endmodule

// File: rtl/ins_fetch.sv
// ins_fetch: instruction fetch / decode sequencer.
// Optional feature macro: INS_FETCH_TIMEOUT_EN (ack wait limit of
// TIMEOUT_CYCLES, sets sticky fetch_err and halts on expiry).
// Ports:
//   clk, RST    - clock, async active-low reset
//   pc          - current program counter
//   zero        - ALU zero flag, sampled during DECODE
//   imem        - instruction memory bus (master side)
//   ins         - latched instruction word
//   ins_valid   - one-cycle pulse after DECODE; ins/sel/immd* valid
//   sel         - registered next-PC select
//   immd16/26   - registered immediate fields of ins
//   halted      - high in HALTED
//   fetch_err   - sticky ack timeout flag (0 when the feature is off)
//
// state    | meaning
// IDLE     | after reset, moves to REQ on the next edge
// REQ      | imem_req=1, imem_addr=pc, waiting for imem_ack
// DECODE   | one cycle, sel resolved from ins and zero
// HALTED   | halt opcode or ack timeout; left only by reset
module ins_fetch
  import ins_fetch_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              RST,
  input  logic [31:0]       pc,
  input  logic              zero,
  ins_fetch_if.master       imem,
  output logic [31:0]       ins,
  output logic              ins_valid,
  output logic [1:0]        sel,
  output logic [15:0]       immd16,
  output logic [25:0]       immd26,
  output logic              halted,
  output logic              fetch_err
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("ins_fetch: TIMEOUT_CYCLES must be in 2..255");
  end

  state_e state, state_nxt;
  sel_e   sel_dec;
  logic   timeout_hit;

  ins_decode u_decode (
    .opcode (ins[31:26]),
    .zero   (zero),
    .sel    (sel_dec)
  );

`ifdef INS_FETCH_TIMEOUT_EN
  logic [7:0] wait_cnt;
  logic       err_q;

  // Counter is held at zero outside REQ, so it is clear on every REQ entry.
  assign timeout_hit = (state == S_REQ) && !imem.imem_ack &&
                       (wait_cnt == 8'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state != S_REQ)
        wait_cnt <= '0;
      else if (!imem.imem_ack)
        wait_cnt <= wait_cnt + 8'd1;
      if (timeout_hit)
        err_q <= 1'b1;
    end
  end

  assign fetch_err = err_q;
`else
  assign timeout_hit = 1'b0;
  assign fetch_err   = 1'b0;
`endif

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   state_nxt = S_REQ;
      S_REQ: begin
        if (imem.imem_ack)  state_nxt = S_DECODE;
        else if (timeout_hit) state_nxt = S_HALTED;
      end
      S_DECODE: state_nxt = (sel_dec == SEL_HALT) ? S_HALTED : S_REQ;
      S_HALTED: state_nxt = S_HALTED;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Request is decoded straight from state so reset removes it immediately.
  assign imem.imem_req  = (state == S_REQ);
  assign imem.imem_addr = (state == S_REQ) ? pc : 32'h0;
  assign halted         = (state == S_HALTED);

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      ins       <= '0;
      ins_valid <= 1'b0;
      sel       <= SEL_NEXT;
      immd16    <= '0;
      immd26    <= '0;
    end else begin
      ins_valid <= (state == S_DECODE);
      if (state == S_REQ && imem.imem_ack)
        ins <= imem.imem_rdata;
      if (state == S_DECODE) begin
        sel    <= sel_dec;
        immd16 <= ins[15:0];
        immd26 <= ins[25:0];
      end
      if (timeout_hit)
        sel <= SEL_HALT;
    end
  end

endmodule

// File: tb/tb_ins_fetch.sv
// tb_ins_fetch: self-checking bench for ins_fetch with a transaction-level
// reference model, directed scenarios and a randomized stretch.
module tb_ins_fetch;

`ifdef INS_FETCH_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 16;
`endif

  logic        clk = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] pc = 32'h40;
  logic        zero = 1'b0;
  logic [31:0] ins;
  logic        ins_valid;
  logic [1:0]  sel;
  logic [15:0] immd16;
  logic [25:0] immd26;
  logic        halted;
  logic        fetch_err;

  int n_cmp = 0;
  int n_bad = 0;

  ins_fetch_if bus();

  ins_fetch #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk       (clk),
    .RST       (RST),
    .pc        (pc),
    .zero      (zero),
    .imem      (bus),
    .ins       (ins),
    .ins_valid (ins_valid),
    .sel       (sel),
    .immd16    (immd16),
    .immd26    (immd26),
    .halted    (halted),
    .fetch_err (fetch_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [1:0] exp_sel(input logic [31:0] w, input logic z);
    case (w[31:26])
      6'd2:    return 2'd2;
      6'd4:    return z ? 2'd1 : 2'd0;
      6'd5:    return z ? 2'd0 : 2'd1;
      6'd63:   return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  bit          m_idle = 1, m_dec = 0, m_stop = 0, m_err = 0, m_valid = 0;
  logic [31:0] m_ins = 0, m_word = 0;
  logic [1:0]  m_sel = 0;
  logic [15:0] m_i16 = 0;
  logic [25:0] m_i26 = 0;
  int          m_wait = 0;

  always @(posedge clk or negedge RST) begin
    bit cur_req;
    if (!RST) begin
      m_idle = 1; m_dec = 0; m_stop = 0; m_err = 0; m_valid = 0;
      m_ins = 0; m_word = 0; m_sel = 0; m_i16 = 0; m_i26 = 0; m_wait = 0;
    end else begin
      cur_req = !m_idle && !m_dec && !m_stop;
      m_valid = m_dec;
      if (m_dec) begin
        m_sel = exp_sel(m_word, zero);
        m_i16 = m_word[15:0];
        m_i26 = m_word[25:0];
        if (m_word[31:26] == 6'h3f) m_stop = 1;
      end
      if (cur_req && bus.imem_ack) begin
        m_ins  = bus.imem_rdata;
        m_word = bus.imem_rdata;
        m_wait = 0;
      end else if (cur_req) begin
        m_wait++;
`ifdef INS_FETCH_TIMEOUT_EN
        if (m_wait == TMO) begin
          m_stop = 1; m_err = 1; m_sel = 2'd3;
        end
`endif
      end else begin
        m_wait = 0;
      end
      m_dec  = cur_req && bus.imem_ack;
      m_idle = 0;
    end
  end

  always @(negedge clk) begin
    bit er;
    er = !m_idle && !m_dec && !m_stop;
    check("imem_req",  bus.imem_req, er);
    check("imem_addr", bus.imem_addr, er ? pc : 32'h0);
    check("ins",       ins, m_ins);
    check("ins_valid", ins_valid, m_valid);
    check("sel",       sel, m_sel);
    check("immd16",    immd16, m_i16);
    check("immd26",    immd26, m_i26);
    check("halted",    halted, m_stop);
    check("fetch_err", fetch_err, m_err);
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #3;
  endtask

  // Wait (bounded) for a request, ack it with w, then let DECODE complete
  // with zero=z. Returns just after the edge where ins_valid rises.
  task automatic fetch(input logic [31:0] w, input logic z);
    int n = 0;
    while (!bus.imem_req && n < 10) begin
      cyc();
      n++;
    end
    check("fetch_wait_req", bus.imem_req, 1'b1);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = w;
    cyc();
    bus.imem_ack = 1'b0;
    zero = z;
    cyc();
  endtask

  initial begin
    logic [5:0] op;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'h0;
    #1 RST = 1'b0;
    cyc();
    cyc();
    check("rst_req", bus.imem_req, 1'b0);
    check("rst_ins", ins, 32'h0);
    check("rst_sel", sel, 2'b00);
    check("rst_err", fetch_err, 1'b0);

    // First fetch after reset release.
    RST = 1'b1;
    cyc();
    check("s1_req",  bus.imem_req, 1'b1);
    check("s1_addr", bus.imem_addr, 32'h40);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h20010005;
    cyc();
    bus.imem_ack = 1'b0;
    check("s1_ins",    ins, 32'h20010005);
    check("s1_novld",  ins_valid, 1'b0);
    cyc();
    check("s1_valid",  ins_valid, 1'b1);
    check("s1_sel",    sel, 2'b00);
    check("s1_immd16", immd16, 32'h5);

    fetch(32'h08000010, 1'b0);
    check("j_sel",    sel, 2'b10);
    check("j_immd26", immd26, 32'h0000010);
    fetch(32'h1000FFFE, 1'b1);
    check("beq1_sel",    sel, 2'b01);
    check("beq1_immd16", immd16, 32'hFFFE);
    fetch(32'h1000FFFE, 1'b0);
    check("beq0_sel", sel, 2'b00);
    fetch(32'h14000003, 1'b0);
    check("bne0_sel", sel, 2'b01);

    // Randomized stretch: random pc/zero, stray acks, varied opcodes.
    repeat (400) begin
      pc   = $urandom;
      zero = 1'($urandom_range(0, 1));
      bus.imem_ack = ($urandom_range(0, 2) == 0) || (m_wait >= TMO - 2);
      case ($urandom_range(0, 4))
        0: op = 6'd2;
        1: op = 6'd4;
        2: op = 6'd5;
        3: op = 6'd0;
        default: op = 6'($urandom_range(0, 62));
      endcase
      bus.imem_rdata = {op, 26'($urandom)};
      cyc();
    end
    bus.imem_ack = 1'b0;

    // Reset during REQ with ack high: request drops at once, word discarded.
    fetch(32'h0, 1'b0);
    pc = 32'h100;
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hDEADBEEF;
    RST = 1'b0;
    #1;
    check("rr_req",  bus.imem_req, 1'b0);
    check("rr_ins",  ins, 32'h0);
    cyc();
    check("rr_ins2", ins, 32'h0);
    RST = 1'b1;
    bus.imem_ack = 1'b0;
    #1;
    check("rr_idle", bus.imem_req, 1'b0);
    cyc();
    check("rr_req2",  bus.imem_req, 1'b1);
    check("rr_addr2", bus.imem_addr, 32'h100);

    // Ack withheld from REQ entry.
`ifdef INS_FETCH_TIMEOUT_EN
    repeat (3) cyc();
    check("tmo_early_halt", halted, 1'b0);
    cyc();
    check("tmo_halted", halted, 1'b1);
    check("tmo_err",    fetch_err, 1'b1);
    check("tmo_sel",    sel, 2'b11);
    check("tmo_req",    bus.imem_req, 1'b0);
`else
    repeat (50) begin
      cyc();
      check("hold_req", bus.imem_req, 1'b1);
      check("hold_err", fetch_err, 1'b0);
    end
`endif

    // Halt opcode.
    RST = 1'b0;
    cyc();
    RST = 1'b1;
    cyc();
    fetch(32'hFC000000, 1'b0);
    check("halt_valid",  ins_valid, 1'b1);
    check("halt_halted", halted, 1'b1);
    check("halt_sel",    sel, 2'b11);
    repeat (20) begin
      cyc();
      check("halt_noreq", bus.imem_req, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
